// File: rtl/snake_link_pkg.sv
// Shared types and constants for the board-to-board link transmit path.
package snake_link_pkg;

  typedef logic [2:0] link_state_e;

  localparam link_state_e ST_IDLE = 3'd0;
  localparam link_state_e ST_SYNC = 3'd1;
  localparam link_state_e ST_TYPE = 3'd2;
  localparam link_state_e ST_DATA = 3'd3;
  localparam link_state_e ST_CSUM = 3'd4;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam logic [3:0] TYPE_HEARTBEAT    = 4'hF;

  typedef struct packed {
    logic [3:0]  pkt_type;
    logic [31:0] data;
  } link_pkt_t;

  // The checksum covers the zero-extended type byte and the four payload bytes.
  function automatic logic [7:0] link_csum(input link_pkt_t pkt);
    return {4'h0, pkt.pkt_type} ^ pkt.data[7:0] ^ pkt.data[15:8]
           ^ pkt.data[23:16] ^ pkt.data[31:24];
  endfunction

endpackage

// File: rtl/link_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  localparam int SW = IW + 1;

  logic [N-1:0]  rot;
  logic [SW-1:0] sum;

  // Rotating the request vector by ptr turns the search into a plain priority scan.
  always_comb begin
    rot        = N'({req, req} >> ptr);
    any        = 1'b0;
    sum        = '0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    for (int k = 0; k < N; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + SW'(k);
      end
    end
    if (sum >= SW'(N)) sum = sum - SW'(N);
    gnt_idx = sum[IW-1:0];
    if (any) gnt_onehot = N'(1) << gnt_idx;
  end

endmodule

// File: rtl/link_tx_scheduler.sv
// Round-robin packet scheduler framing SYNC/TYPE/D0..D3/CSUM onto a UART TX byte stream.
// Optional idle heartbeat packets are enabled by defining LINK_HEARTBEAT_EN.
module link_tx_scheduler
  import snake_link_pkg::*;
#(
  parameter int          N_REQ     = 3,
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
`ifdef LINK_HEARTBEAT_EN
  , parameter int unsigned HB_PERIOD = 75_000_000
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*4-1:0]    req_type,
  input  logic [N_REQ*32-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  link_state_e      state;
  logic [1:0]       byte_cnt;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    gnt_idx;
  logic [IW-1:0]    next_ptr;
  logic [N_REQ-1:0] gnt_onehot;
  logic             gnt_any;
  logic             hb_fire;
  link_pkt_t        pkt;
  link_pkt_t        req_pkt;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  assign req_pkt.pkt_type = req_type[{gnt_idx, 2'b00} +: 4];
  assign req_pkt.data     = req_data[{gnt_idx, 5'b00000} +: 32];
  assign next_ptr = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);

  assign tx_valid = (state != ST_IDLE);
  assign busy     = (state != ST_IDLE);

`ifdef LINK_HEARTBEAT_EN
  logic [31:0] idle_cnt;

  // A real request in the expiry cycle takes priority and restarts the idle count.
  assign hb_fire = (state == ST_IDLE) && !gnt_any && (idle_cnt == 32'(HB_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst || state != ST_IDLE || gnt_any || hb_fire) idle_cnt <= '0;
    else                                              idle_cnt <= idle_cnt + 32'd1;
  end
`else
  assign hb_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      byte_cnt  <= '0;
      rr_ptr    <= '0;
      pkt       <= '0;
      req_ready <= '0;
    end else begin
      req_ready <= '0;
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            pkt       <= req_pkt;
            req_ready <= gnt_onehot;
            rr_ptr    <= next_ptr;
            state     <= ST_SYNC;
          end else if (hb_fire) begin
            pkt   <= '{pkt_type: TYPE_HEARTBEAT, data: 32'h0};
            state <= ST_SYNC;
          end
        end
        ST_SYNC: if (tx_ready) state <= ST_TYPE;
        ST_TYPE: begin
          if (tx_ready) begin
            byte_cnt <= '0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tx_ready) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) state <= ST_CSUM;
          end
        end
        ST_CSUM: if (tx_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_data = 8'h00;
    case (state)
      ST_SYNC: tx_data = SYNC_BYTE;
      ST_TYPE: tx_data = {4'h0, pkt.pkt_type};
      ST_DATA: tx_data = pkt.data[{byte_cnt, 3'b000} +: 8];
      ST_CSUM: tx_data = link_csum(pkt);
      default: tx_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_link_tx_scheduler.sv
// Directed self-checking bench for link_tx_scheduler (3 sources, heartbeat scenario when LINK_HEARTBEAT_EN is defined).
module tb_link_tx_scheduler;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [11:0] req_type;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;

  int n_checks;
  int n_fail;

  logic       tr_v [0:79];
  logic [7:0] tr_d [0:79];
  logic [2:0] tr_r [0:79];

  link_tx_scheduler #(
    .N_REQ     (3),
    .SYNC_BYTE (8'hA5)
`ifdef LINK_HEARTBEAT_EN
    , .HB_PERIOD (16)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_type  (req_type),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [3:0] t, input logic [31:0] d);
    req_type[4*i +: 4]  = t;
    req_data[32*i +: 32] = d;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 3'b000;
    tx_ready  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Gathers seven transferred bytes; optionally toggles tx_ready before each edge.
  task automatic collect_frame(input bit toggle, output logic [55:0] got, output int n,
                               output int vcyc, output logic [2:0] ror, output int rcnt,
                               output bit stable_ok);
    logic [7:0] held;
    bit         holding;
    int         guard;
    got = '0; n = 0; vcyc = 0; ror = '0; rcnt = 0; stable_ok = 1'b1;
    holding = 1'b0; held = '0; guard = 0;
    while (n < 7 && guard < 200) begin
      if (toggle) tx_ready = ~tx_ready;
      if (req_ready != 3'b000) begin
        ror = ror | req_ready;
        rcnt++;
      end
      if (holding && tx_data !== held) stable_ok = 1'b0;
      if (tx_valid) vcyc++;
      if (tx_valid && tx_ready) begin
        got[8*n +: 8] = tx_data;
        n++;
        holding = 1'b0;
      end else if (tx_valid) begin
        held    = tx_data;
        holding = 1'b1;
      end
      tick();
      guard++;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    tx_ready  = 1'b1;
    set_src(0, 4'h3, 32'h44332211);
    set_src(1, 4'h2, 32'h80402010);
    set_src(2, 4'hC, 32'hDEADBEEF);
    req_valid = 3'b111;
    tick();
    tick();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset tx_valid: got %b, expected 0", tx_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset busy: got %b, expected 0", busy); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset tx_data: got %h, expected 00", tx_data); end
    n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("[TB] FAIL reset req_ready: got %b, expected 000", req_ready); end
    req_valid = 3'b000;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [55:0] got, exp;
    int n, vcyc, rcnt;
    logic [2:0] ror;
    bit stab;
    do_reset();
    set_src(0, 4'h3, 32'h44332211);
    req_valid = 3'b001;
    tick();
    req_valid = 3'b000;
    collect_frame(1'b0, got, n, vcyc, ror, rcnt, stab);
    exp = 56'h47_44_33_22_11_03_A5;
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (got[8*i +: 8] !== exp[8*i +: 8]) begin
        n_fail++; $display("[TB] FAIL single byte%0d: got %h, expected %h", i, got[8*i +: 8], exp[8*i +: 8]);
      end
    end
    n_checks++; if (n !== 7) begin n_fail++; $display("[TB] FAIL single byte count: got %0d, expected 7", n); end
    n_checks++; if (vcyc !== 7) begin n_fail++; $display("[TB] FAIL single valid cycles: got %0d, expected 7", vcyc); end
    n_checks++; if (ror !== 3'b001) begin n_fail++; $display("[TB] FAIL single req_ready src: got %b, expected 001", ror); end
    n_checks++; if (rcnt !== 1) begin n_fail++; $display("[TB] FAIL single req_ready pulses: got %0d, expected 1", rcnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL single busy after frame: got %b, expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [55:0] fr [3];
    logic [7:0]  eb;
    logic [2:0]  er;
    int src;
    do_reset();
    set_src(0, 4'h1, 32'h04030201);
    set_src(1, 4'h2, 32'h80402010);
    set_src(2, 4'hC, 32'hDEADBEEF);
    fr[0] = 56'h05_04_03_02_01_01_A5;
    fr[1] = 56'hF2_80_40_20_10_02_A5;
    fr[2] = 56'h2E_DE_AD_BE_EF_0C_A5;
    req_valid = 3'b111;
    for (int t = 0; t < 32; t++) begin
      tr_v[t] = tx_valid; tr_d[t] = tx_data; tr_r[t] = req_ready;
      tick();
    end
    req_valid = 3'b000;
    for (int k = 0; k < 4; k++) begin
      src = k % 3;
      er  = 3'b001 << src;
      n_checks++;
      if (tr_r[8*k+1] !== er) begin
        n_fail++; $display("[TB] FAIL b2b grant pkt%0d: got %b, expected %b", k, tr_r[8*k+1], er);
      end
      if (k > 0) begin
        n_checks++;
        if (tr_v[8*k] !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b gap pkt%0d tx_valid: got %b, expected 0", k, tr_v[8*k]); end
      end
      for (int j = 0; j < 7; j++) begin
        eb = fr[src][8*j +: 8];
        n_checks++;
        if ({tr_v[8*k+1+j], tr_d[8*k+1+j]} !== {1'b1, eb}) begin
          n_fail++; $display("[TB] FAIL b2b pkt%0d byte%0d: got valid=%b data=%h, expected valid=1 data=%h",
                             k, j, tr_v[8*k+1+j], tr_d[8*k+1+j], eb);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [55:0] got, exp;
    int n, vcyc, rcnt;
    logic [2:0] ror;
    bit stab;
    do_reset();
    set_src(1, 4'h2, 32'h80402010);
    req_valid = 3'b010;
    tick();
    req_valid = 3'b000;
    tx_ready  = 1'b1;
    collect_frame(1'b1, got, n, vcyc, ror, rcnt, stab);
    tx_ready = 1'b1;
    exp = 56'hF2_80_40_20_10_02_A5;
    n_checks++; if (got !== exp) begin n_fail++; $display("[TB] FAIL stall frame: got %h, expected %h", got, exp); end
    n_checks++; if (vcyc !== 14) begin n_fail++; $display("[TB] FAIL stall valid cycles: got %0d, expected 14", vcyc); end
    n_checks++; if (stab !== 1'b1) begin n_fail++; $display("[TB] FAIL stall data stable: got %b, expected 1", stab); end
    n_checks++; if (ror !== 3'b010) begin n_fail++; $display("[TB] FAIL stall req_ready src: got %b, expected 010", ror); end
  endtask

  task automatic test_payload_change();
    logic [55:0] got, exp;
    int n, vcyc, rcnt;
    logic [2:0] ror;
    bit stab;
    do_reset();
    set_src(1, 4'h2, 32'h80402010);
    req_valid = 3'b010;
    tick();
    set_src(1, 4'h7, 32'hFFFFFFFF);
    collect_frame(1'b0, got, n, vcyc, ror, rcnt, stab);
    req_valid = 3'b000;
    exp = 56'hF2_80_40_20_10_02_A5;
    n_checks++; if (got !== exp) begin n_fail++; $display("[TB] FAIL latched payload frame: got %h, expected %h", got, exp); end
    n_checks++; if (rcnt !== 1) begin n_fail++; $display("[TB] FAIL latched payload ready pulses: got %0d, expected 1", rcnt); end
  endtask

  task automatic test_mid_reset();
    logic [55:0] got, exp;
    int n, vcyc, rcnt;
    logic [2:0] ror;
    bit stab;
    do_reset();
    set_src(0, 4'h3, 32'h44332211);
    req_valid = 3'b001;
    tick();
    req_valid = 3'b000;
    tick();
    n_checks++; if (tx_data !== 8'h03) begin n_fail++; $display("[TB] FAIL midrst type byte: got %h, expected 03", tx_data); end
    tick();
    n_checks++; if (tx_data !== 8'h11) begin n_fail++; $display("[TB] FAIL midrst d0 byte: got %h, expected 11", tx_data); end
    rst = 1'b1;
    tick();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst tx_valid: got %b, expected 0", tx_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst busy: got %b, expected 0", busy); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL midrst tx_data: got %h, expected 00", tx_data); end
    rst = 1'b0;
    set_src(2, 4'hC, 32'hDEADBEEF);
    req_valid = 3'b100;
    tick();
    req_valid = 3'b000;
    collect_frame(1'b0, got, n, vcyc, ror, rcnt, stab);
    exp = 56'h2E_DE_AD_BE_EF_0C_A5;
    n_checks++; if (got !== exp) begin n_fail++; $display("[TB] FAIL midrst fresh frame: got %h, expected %h", got, exp); end
    n_checks++; if (ror !== 3'b100) begin n_fail++; $display("[TB] FAIL midrst grant: got %b, expected 100", ror); end
  endtask

`ifndef LINK_HEARTBEAT_EN
  task automatic test_idle_silent();
    int seen;
    do_reset();
    seen = 0;
    for (int t = 0; t < 40; t++) begin
      if (tx_valid || busy) seen++;
      tick();
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("[TB] FAIL idle silent: got %0d active cycles, expected 0", seen); end
  endtask
`else
  task automatic test_heartbeat();
    logic [55:0] hb, rf;
    logic [7:0]  eb;
    int pulses;
    do_reset();
    set_src(0, 4'h3, 32'h44332211);
    hb = 56'h0F_00_00_00_00_0F_A5;
    rf = 56'h47_44_33_22_11_03_A5;
    for (int t = 0; t < 70; t++) begin
      tr_v[t] = tx_valid; tr_d[t] = tx_data; tr_r[t] = req_ready;
      if (t == 61) req_valid = 3'b001;
      if (t == 62) req_valid = 3'b000;
      tick();
    end
    for (int j = 0; j < 7; j++) begin
      eb = hb[8*j +: 8];
      n_checks++;
      if ({tr_v[16+j], tr_d[16+j]} !== {1'b1, eb}) begin
        n_fail++; $display("[TB] FAIL hb1 byte%0d: got valid=%b data=%h, expected valid=1 data=%h", j, tr_v[16+j], tr_d[16+j], eb);
      end
      n_checks++;
      if ({tr_v[39+j], tr_d[39+j]} !== {1'b1, eb}) begin
        n_fail++; $display("[TB] FAIL hb2 byte%0d: got valid=%b data=%h, expected valid=1 data=%h", j, tr_v[39+j], tr_d[39+j], eb);
      end
      eb = rf[8*j +: 8];
      n_checks++;
      if ({tr_v[62+j], tr_d[62+j]} !== {1'b1, eb}) begin
        n_fail++; $display("[TB] FAIL hb preempt byte%0d: got valid=%b data=%h, expected valid=1 data=%h", j, tr_v[62+j], tr_d[62+j], eb);
      end
    end
    n_checks++; if (tr_v[15] !== 1'b0) begin n_fail++; $display("[TB] FAIL hb1 early start: got %b, expected 0", tr_v[15]); end
    n_checks++; if (tr_v[38] !== 1'b0) begin n_fail++; $display("[TB] FAIL hb2 early start: got %b, expected 0", tr_v[38]); end
    pulses = 0;
    for (int t = 0; t < 62; t++) if (tr_r[t] != 3'b000) pulses++;
    n_checks++; if (pulses !== 0) begin n_fail++; $display("[TB] FAIL hb req_ready pulses: got %0d, expected 0", pulses); end
    n_checks++; if (tr_r[62] !== 3'b001) begin n_fail++; $display("[TB] FAIL hb preempt grant: got %b, expected 001", tr_r[62]); end
  endtask
`endif

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_valid = 3'b000;
    req_type  = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_payload_change();
    test_mid_reset();
`ifndef LINK_HEARTBEAT_EN
    test_idle_silent();
`else
    test_heartbeat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
